// File: rtl/axis_i2s_tx.sv
// Stereo I2S transmitter: one-pair holding register in front of a frame shifter,
// with bclk/lrclk/sdata all derived from the system clock.
module axis_i2s_tx #(
    parameter int SAMPLE_W = 24,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2*SAMPLE_W-1:0] s_data,
    input  logic                  s_vld,
    output logic                  s_rdy,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  sdata,
    output logic                  underrun
);
    localparam int FRAME_W = 2 * SLOT_W;
    localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_RIGHT = CNT_W'(SLOT_W);

    logic                  run_q,   run_d;
    logic                  full_q,  full_d;
    logic [2*SAMPLE_W-1:0] hold_q;
    logic [DIV_W-1:0]      div_q,   div_d;
    logic                  bclk_q,  bclk_d;
    logic [CNT_W-1:0]      bit_q,   bit_d;
    logic [FRAME_W-1:0]    shift_q, shift_d;
    logic                  sdata_q, sdata_d;
    logic                  und_q,   und_d;

    logic                  xfer;
    logic                  wrap;
    logic                  fall;
    logic                  frame_start;
    logic [SLOT_W-1:0]     left_slot;
    logic [SLOT_W-1:0]     right_slot;
    logic [FRAME_W-1:0]    load_word;

    // Samples are left-justified in their slot, padded with zeros below the LSB.
    assign left_slot  = SLOT_W'(hold_q[2*SAMPLE_W-1:SAMPLE_W]) << (SLOT_W - SAMPLE_W);
    assign right_slot = SLOT_W'(hold_q[SAMPLE_W-1:0]) << (SLOT_W - SAMPLE_W);
    assign load_word  = {left_slot, right_slot};

    assign s_rdy    = run_q & ~full_q;
    assign xfer     = s_vld & s_rdy;
    assign bclk     = bclk_q;
    assign lrclk    = (bit_q >= CNT_RIGHT);
    assign sdata    = sdata_q;
    assign underrun = und_q;

    always_comb begin
        wrap        = (div_q == DIV_LAST);
        fall        = wrap & bclk_q;
        frame_start = fall & (bit_q == CNT_LAST);

        run_d   = 1'b1;
        div_d   = wrap ? '0 : div_q + 1'b1;
        bclk_d  = wrap ? ~bclk_q : bclk_q;
        bit_d   = bit_q;
        full_d  = full_q;
        shift_d = shift_q;
        sdata_d = sdata_q;
        und_d   = 1'b0;

        if (fall) begin
            // The bit leaving on a frame start is the previous frame's last bit,
            // which yields the one-bclk I2S delay after lrclk changes.
            sdata_d = shift_q[FRAME_W-1];
            bit_d   = frame_start ? '0 : bit_q + 1'b1;
            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
            if (frame_start) begin
                if (full_q) begin
                    shift_d = load_word;
                    full_d  = 1'b0;
                end else begin
                    shift_d = '0;
                    und_d   = 1'b1;
                end
            end
        end

        // A transfer only happens while empty, so it never collides with a load.
        if (xfer) begin
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            full_q  <= 1'b0;
            div_q   <= '0;
            bclk_q  <= 1'b0;
            bit_q   <= CNT_LAST;
            shift_q <= '0;
            sdata_q <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            run_q   <= run_d;
            full_q  <= full_d;
            div_q   <= div_d;
            bclk_q  <= bclk_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            sdata_q <= sdata_d;
            und_q   <= und_d;
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            hold_q <= s_data;
        end
    end

endmodule

// File: tb/tb_axis_i2s_tx.sv
// Bench for axis_i2s_tx: frame-level arithmetic model of the serial stream,
// directed scenarios plus randomized traffic, and a small-parameter corner instance.
module tb_axis_i2s_tx;
    localparam int SW        = 24;
    localparam int SL        = 32;
    localparam int D         = 2;
    localparam int FW        = 2 * SL;
    localparam int FRAME_CLK = FW * 2 * D;

    localparam int CSW = 16;
    localparam int CSL = 16;
    localparam int CD  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [2*SW-1:0] s_data;
    logic          s_vld;
    logic          s_rdy;
    logic          bclk;
    logic          lrclk;
    logic          sdata;
    logic          underrun;

    logic          rst_c_n;
    logic [2*CSW-1:0] c_data;
    logic          c_vld;
    logic          c_rdy;
    logic          c_bclk;
    logic          c_lrclk;
    logic          c_sdata;
    logic          c_under;

    axis_i2s_tx #(.SAMPLE_W(SW), .SLOT_W(SL), .BCLK_DIV(D)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_data   (s_data),
        .s_vld    (s_vld),
        .s_rdy    (s_rdy),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .sdata    (sdata),
        .underrun (underrun)
    );

    axis_i2s_tx #(.SAMPLE_W(CSW), .SLOT_W(CSL), .BCLK_DIV(CD)) u_corner (
        .clk      (clk),
        .rst_n    (rst_c_n),
        .s_data   (c_data),
        .s_vld    (c_vld),
        .s_rdy    (c_rdy),
        .bclk     (c_bclk),
        .lrclk    (c_lrclk),
        .sdata    (c_sdata),
        .underrun (c_under)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Model state: edges since release, held pair, and the word each frame carries.
    int              k;
    bit              m_full;
    logic [2*SW-1:0] m_hold;
    logic [FW-1:0]   m_word[$];
    bit              m_und;
    logic [FW-1:0]   rx;
    int              und_cnt;
    int              obs_xfer;
    bit              xfer_last;
    int              mode;
    int              pat_n;
    bit              stream_chk;

    function automatic logic [FW-1:0] expand(input logic [2*SW-1:0] p);
        logic [FW-1:0] w;
        w = '0;
        w[FW-1 -: SW] = p[2*SW-1 -: SW];
        w[SL-1 -: SW] = p[SW-1:0];
        return w;
    endfunction

    function automatic logic [2*SW-1:0] pat(input int n);
        logic [SW-1:0] l;
        logic [SW-1:0] r;
        l = 24'h800000 + 24'(n);
        r = 24'h7FFFFF - 24'(n * 5);
        return {l, r};
    endfunction

    task automatic model_reset();
        k         = 0;
        m_full    = 1'b0;
        m_hold    = '0;
        m_word.delete();
        m_und     = 1'b0;
        rx        = '0;
        und_cnt   = 0;
        obs_xfer  = 0;
        xfer_last = 1'b0;
        pat_n     = 0;
    endtask

    task automatic step();
        bit              xfer;
        bit              fs;
        int              f;
        int              idx;
        int              pos;
        int              exp_bit;
        logic            es;
        logic [FW-1:0]   w;
        logic [2*SW-1:0] d;
        xfer = s_vld && (k >= 1) && !m_full;
        d    = s_data;
        if (s_vld && s_rdy) obs_xfer++;
        @(posedge clk);
        k++;
        f  = k / (2 * D);
        fs = (k % (2 * D) == 0) && ((f - 1) % FW == 0);
        m_und = 1'b0;
        if (fs) begin
            if (m_full) begin
                m_word.push_back(expand(m_hold));
                m_full = 1'b0;
            end else begin
                m_word.push_back('0);
                m_und = 1'b1;
            end
        end
        if (xfer) begin
            m_full = 1'b1;
            m_hold = d;
        end
        xfer_last = xfer;
        #1;
        if (k % (2 * D) == 0) rx = {rx[FW-2:0], sdata};
        exp_bit = (FW - 1 + f) % FW;
        es = 1'b0;
        if (f >= 2) begin
            idx = (f - 2) / FW;
            pos = (f - 2) % FW;
            w   = m_word[idx];
            es  = w[FW-1-pos];
        end
        if (underrun === 1'b1) und_cnt++;
        check("bclk", bclk, (k / D) % 2);
        check("lrclk", lrclk, exp_bit >= SL);
        check("sdata", sdata, es);
        check("underrun", underrun, m_und);
        check("s_rdy", s_rdy, !m_full);
        if (fs && m_word.size() >= 2) begin
            check("frame", rx, m_word[m_word.size()-2]);
            if (stream_chk) check("order", rx, expand(pat(m_word.size() - 2)));
        end
    endtask

    task automatic drive();
        case (mode)
            0: s_vld = 1'b0;
            1: begin
                if (xfer_last) pat_n++;
                s_vld  = 1'b1;
                s_data = pat(pat_n);
            end
            2: begin
                if (xfer_last || !s_vld) begin
                    s_vld  = ($urandom_range(0, 199) == 0);
                    s_data = {24'($urandom), 24'($urandom)};
                end
            end
            default: if (xfer_last) s_vld = 1'b0;
        endcase
    endtask

    task automatic run(input int n);
        repeat (n) begin
            step();
            drive();
        end
    endtask

    task automatic check_rst(input string tag);
        check({tag, "_bclk"}, bclk, 0);
        check({tag, "_lrclk"}, lrclk, 1);
        check({tag, "_sdata"}, sdata, 0);
        check({tag, "_s_rdy"}, s_rdy, 0);
        check({tag, "_underrun"}, underrun, 0);
    endtask

    task automatic do_reset();
        s_vld  = 1'b0;
        s_data = '0;
        mode   = 0;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    logic [31:0] cpair;
    logic [31:0] cw;

    initial begin
        rst_n      = 1'b0;
        rst_c_n    = 1'b0;
        s_vld      = 1'b0;
        s_data     = '0;
        c_vld      = 1'b0;
        c_data     = '0;
        stream_chk = 1'b0;
        model_reset();

        // Idle: silence, one underrun per frame
        do_reset();
        check_rst("rst");
        run(3 * FRAME_CLK);
        check("idle_und", und_cnt, 3);

        // Single pair ahead of the first frame
        do_reset();
        run(1);
        s_vld  = 1'b1;
        s_data = {24'h800001, 24'h7FFFFF};
        mode   = 3;
        run(258);
        check("pair_und", und_cnt, 0);
        run(1);
        check("pair_word", rx, 64'h80000100_7FFFFF00);
        run(256);
        check("pair_next", rx, 64'h0);
        check("pair_next_und", und_cnt, 2);

        // Back-to-back streaming
        do_reset();
        mode       = 1;
        s_vld      = 1'b1;
        s_data     = pat(0);
        stream_chk = 1'b1;
        run(4 + 10 * FRAME_CLK);
        stream_chk = 1'b0;
        check("stream_und", und_cnt, 0);
        check("stream_xfers", obs_xfer, 11);

        // Late arrival: one clk after a frame start
        do_reset();
        run(260);
        s_vld  = 1'b1;
        s_data = {24'h123456, 24'hABCDEF};
        mode   = 3;
        run(256);
        check("late_und", und_cnt, 2);
        check("late_silent", rx, 64'h0);
        run(256);
        check("late_word", rx, 64'h12345600_ABCDEF00);

        // Randomized traffic
        do_reset();
        mode = 2;
        run(8 * FRAME_CLK);

        // Reset mid-frame with a pair held
        do_reset();
        run(1);
        s_vld  = 1'b1;
        s_data = {24'h5A5A5A, 24'hFFFFFF};
        mode   = 3;
        run(4);
        s_vld  = 1'b1;
        s_data = {24'h111111, 24'h222222};
        run(161);
        check("pre_bclk", bclk, 1);
        check("pre_sdata", sdata, 1);
        check("pre_s_rdy", s_rdy, 0);
        #2 rst_n = 1'b0;
        #1 check_rst("mid");
        s_vld = 1'b0;
        mode  = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        check_rst("mid_rel");
        run(2 * FRAME_CLK);
        check("mid_und", und_cnt, 2);
        check("mid_rx", rx, 64'h0);

        // Corner: SAMPLE_W = SLOT_W = 16, BCLK_DIV = 1
        cpair = $urandom;
        cw    = '0;
        @(posedge clk);
        #1 rst_c_n = 1'b1;
        check("c_rst_bclk", c_bclk, 0);
        check("c_rst_lrclk", c_lrclk, 1);
        check("c_rst_rdy", c_rdy, 0);
        for (int kc = 1; kc <= 140; kc++) begin
            @(posedge clk);
            #1;
            if (kc <= 20) check("c_bclk", c_bclk, kc % 2);
            if (kc == 1) begin
                check("c_rdy1", c_rdy, 1);
                c_vld  = 1'b1;
                c_data = cpair;
            end
            if (kc == 2) begin
                check("c_und2", c_under, 1);
                check("c_rdy2", c_rdy, 0);
                c_vld = 1'b0;
            end
            if (kc == 66) begin
                check("c_und66", c_under, 0);
                check("c_rdy66", c_rdy, 1);
            end
            if ((kc % 2 == 0) && (kc / 2 >= 34) && (kc / 2 <= 65)) cw = {cw[30:0], c_sdata};
            if (kc == 68) check("c_lmsb", c_sdata, cpair[31]);
            if (kc == 130) begin
                check("c_rlsb", c_sdata, cpair[0]);
                check("c_lrclk", c_lrclk, 0);
            end
        end
        check("c_word", cw, cpair);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
